// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the integer register file.
// Optional same-cycle write bypass: REG_FILE_WRITE_BYPASS_EN.
package reg_file_pkg;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_num_t;
  typedef logic [WIDTH-1:0]  word_t;

  localparam reg_num_t ZERO_REG = '0;

endpackage

// File: rtl/rf_entry.sv
// One register-file entry: write-enabled register with async clear.
// Optional same-cycle write bypass: REG_FILE_WRITE_BYPASS_EN.
module rf_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: 2 async read ports, 1 sync write port, live non-zero count.
// Optional same-cycle write bypass: REG_FILE_WRITE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = reg_file_pkg::WIDTH,
  parameter int DEPTH  = reg_file_pkg::DEPTH,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rn1,
  input  logic [ADDR_W-1:0] rn2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic [ADDR_W-1:0] wn,
  input  logic [WIDTH-1:0]  wd,
  input  logic              w,
  output logic [ADDR_W:0]   nz_count
);

  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [DEPTH-1:0]            we;
  logic                        wr_ok;
  logic [WIDTH-1:0]            old_q;
  logic                        inc;
  logic                        dec;

  assign wr_ok = w && (wn != ADDR_W'(ZERO_REG));

  assign q[0]  = '0;
  assign we[0] = 1'b0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_ent
    assign we[i] = wr_ok && (wn == ADDR_W'(i));
    rf_entry #(
      .WIDTH(WIDTH)
    ) u_ent (
      .clk  (clk),
      .reset(reset),
      .we   (we[i]),
      .d    (wd),
      .q    (q[i])
    );
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  assign rd1 = (wr_ok && rn1 == wn) ? wd : q[rn1];
  assign rd2 = (wr_ok && rn2 == wn) ? wd : q[rn2];
`else
  assign rd1 = q[rn1];
  assign rd2 = q[rn2];
`endif

  // Count tracks zero/non-zero transitions of the entry being overwritten.
  assign old_q = q[wn];
  assign inc   = wr_ok && (old_q == '0) && (wd != '0);
  assign dec   = wr_ok && (old_q != '0) && (wd == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_count <= '0;
    end else if (inc) begin
      nz_count <= nz_count + 1'b1;
    end else if (dec) begin
      nz_count <= nz_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps plus random traffic
// checked against an array model of the register contents.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rn1, rn2, wn;
  logic [31:0] rd1, rd2, wd;
  logic        w;
  logic [5:0]  nz_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [32];

  reg_file dut (
    .clk     (clk),
    .reset   (reset),
    .rn1     (rn1),
    .rn2     (rn2),
    .rd1     (rd1),
    .rd2     (rd2),
    .wn      (wn),
    .wd      (wd),
    .w       (w),
    .nz_count(nz_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_count();
    int n = 0;
    for (int i = 1; i < 32; i++) if (mdl[i] != 0) n++;
    return n;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [4:0] rn,
                                         input logic wen,
                                         input logic [4:0] a,
                                         input logic [31:0] d);
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (wen && a != 0 && rn == a) return d;
`endif
    return (rn == 0) ? 32'h0 : mdl[rn];
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    w = 1'b1; wn = a; wd = d;
    @(posedge clk); #1;
    if (a != 0) mdl[a] = d;
    w = 1'b0;
  endtask

  initial begin
    logic [31:0] exp5;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    reset = 1'b1; w = 1'b0; wn = '0; wd = '0; rn1 = '0; rn2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("nz_in_reset", 32'(nz_count), 0);
    reset = 1'b0;

    // 1: everything reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rn1 = 5'(i); rn2 = 5'(31 - i); #1;
      check("rst_rd1", rd1, 0);
      check("rst_rd2", rd2, 0);
    end
    check("rst_nz", 32'(nz_count), 0);

    // 2: basic write/read
    wr(5, 32'hDEADBEEF);
    rn1 = 5; rn2 = 5; #1;
    check("basic_rd1", rd1, 32'hDEADBEEF);
    check("basic_rd2", rd2, 32'hDEADBEEF);
    check("basic_nz", 32'(nz_count), 1);
    w = 1'b0; wn = 6; wd = 32'h1234;
    @(posedge clk); #1;
    rn1 = 6; #1;
    check("no_we_rd", rd1, 0);

    // 3: register 0 is hardwired
    wr(0, 32'hFFFFFFFF);
    rn1 = 0; #1;
    check("r0_rd", rd1, 0);
    check("r0_nz", 32'(nz_count), 1);

    // 4: count rules
    wr(9, 32'h7);
    check("cnt_inc", 32'(nz_count), 2);
    wr(9, 32'h8);
    check("cnt_same", 32'(nz_count), 2);
    wr(9, 32'h0);
    check("cnt_dec", 32'(nz_count), 1);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h1);
    check("cnt_full", 32'(nz_count), 31);
    check("cnt_mdl", 32'(nz_count), 32'(mdl_count()));

    // 5: same-cycle read of a write
    wr(3, 32'h11);
    rn1 = 3; w = 1'b1; wn = 3; wd = 32'h22; #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    exp5 = 32'h22;
`else
    exp5 = 32'h11;
`endif
    check("rw_before", rd1, exp5);
    @(posedge clk); #1;
    mdl[3] = 32'h22; w = 1'b0;
    check("rw_after", rd1, 32'h22);

    // random traffic against the array model
    for (int k = 0; k < 300; k++) begin
      logic [4:0]  a;
      logic [31:0] d;
      logic        en;
      a  = 5'($urandom_range(0, 31));
      d  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      en = 1'($urandom_range(0, 1));
      w = en; wn = a; wd = d;
      rn1 = 5'($urandom_range(0, 31));
      rn2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      #1;
      check("rnd_rd1", rd1, mdl_rd(rn1, en, a, d));
      check("rnd_rd2", rd2, mdl_rd(rn2, en, a, d));
      @(posedge clk); #1;
      if (en && a != 0) mdl[a] = d;
      w = 1'b0;
      check("rnd_nz", 32'(nz_count), 32'(mdl_count()));
    end

    // 6: async reset between edges, and a write edge under reset
    wr(7, 32'hCAFE0007);
    rn1 = 7; rn2 = 3;
    @(negedge clk);
    reset = 1'b1; #1;
    check("arst_rd1", rd1, 0);
    check("arst_rd2", rd2, 0);
    check("arst_nz", 32'(nz_count), 0);
    w = 1'b1; wn = 4; wd = 32'h5; rn1 = 4;
    @(posedge clk); #1;
    reset = 1'b0; w = 1'b0; #1;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    check("arst_wr_rd", rd1, 0);
    check("arst_wr_nz", 32'(nz_count), 0);
    wr(4, 32'h5);
    check("post_rst_rd", rd1, 32'h5);
    check("post_rst_nz", 32'(nz_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
